// File: rtl/cel_pixel_decoder.sv
// Cel pixel decoder: maps unpacked coded pixels through a 32-entry PLUT (or passes raw/16bpp
// values through), flags transparency and queues pixels plus end-of-line markers in an output FIFO.
module cel_pixel_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  bpp,
  input  logic        coded,
  input  logic [4:0]  plut_base,
  input  logic        bgnd,
  input  logic        flush,
  input  logic        plut_load,
  input  logic        plut_wr,
  input  logic [31:0] plut_din,
  output logic        plut_done,
  input  logic [15:0] pix_in,
  input  logic        pix_valid,
  input  logic        eol_in,
  output logic        in_ready,
  output logic [15:0] out_pix,
  output logic        out_transp,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] RDY_LIM = OW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [15:0] plut_r [32];
  logic [4:0]  wr_k_r;
  logic        plut_done_r;
  logic        plut_we_s;
  logic [3:0]  plut_wa_s;

  logic        s1_v_r, s1_eol_r, s1_lut_r, s1_bgnd_r;
  logic [4:0]  s1_idx_r;
  logic [15:0] s1_raw_r;
  logic        s2_v_r, s2_eol_r, s2_lut_r, s2_bgnd_r;
  logic [15:0] s2_raw_r, s2_plut_r;
  logic        eol_pend_r;

  logic [17:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic [4:0]    idx_s;
  logic [15:0]   raw_s;
  logic          lut_s;
  logic [OW-1:0] occ_s, new_n_s;
  logic          accept_s, drop_s;
  logic [15:0]   res_s;
  logic          transp_s, push_s, pop_s, push_ok_s;
  logic [17:0]   head_s;

  assign plut_we_s = plut_wr && (plut_load || !plut_done_r);
  assign plut_wa_s = plut_load ? 4'd0 : wr_k_r[3:0];

  // PLUT storage; a write and an S2 read of the same entry on one edge yields the old value
  always_ff @(posedge clock) begin
    if (plut_we_s) begin
      plut_r[{plut_wa_s, 1'b0}] <= plut_din[31:16];
      plut_r[{plut_wa_s, 1'b1}] <= plut_din[15:0];
    end
  end

  // PLUT word pointer and load-complete flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_k_r      <= 5'd0;
      plut_done_r <= 1'b0;
    end else if (plut_load) begin
      wr_k_r      <= plut_wr ? 5'd1 : 5'd0;
      plut_done_r <= 1'b0;
    end else if (plut_wr && !plut_done_r) begin
      wr_k_r      <= wr_k_r + 5'd1;
      plut_done_r <= (wr_k_r == 5'd15);
    end else begin
      wr_k_r      <= wr_k_r;
      plut_done_r <= plut_done_r;
    end
  end

  // Index / raw value extraction for the current input depth
  always_comb begin
    idx_s = 5'd0;
    raw_s = 16'h0000;
    case (bpp)
      3'd1: begin idx_s = {plut_base[4:1], pix_in[0]};   raw_s = {15'h0000, pix_in[0]};   end
      3'd2: begin idx_s = {plut_base[4:2], pix_in[1:0]}; raw_s = {14'h0000, pix_in[1:0]}; end
      3'd3: begin idx_s = {plut_base[4],   pix_in[3:0]}; raw_s = {12'h000,  pix_in[3:0]}; end
      3'd4: begin idx_s = pix_in[4:0];                   raw_s = {10'h000,  pix_in[5:0]}; end
      3'd5: begin idx_s = pix_in[4:0];                   raw_s = {8'h00,    pix_in[7:0]}; end
      3'd6: begin idx_s = 5'd0;                          raw_s = pix_in;                  end
      default: begin idx_s = 5'd0;                       raw_s = 16'h0000;                end
    endcase
    lut_s = coded && (bpp != 3'd6);
  end

  // Admission: an input is taken only when every entry it creates is guaranteed a FIFO slot.
  // Any input arriving while a split EOL marker is still pending is lost.
  always_comb begin
    occ_s    = OW'(count_r) + OW'(s1_v_r) + OW'(s2_v_r) + OW'(eol_pend_r);
    new_n_s  = OW'(pix_valid) + OW'(eol_in);
    accept_s = 1'b0;
    drop_s   = 1'b0;
    if (flush) begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end else if ((pix_valid || eol_in) && !eol_pend_r && ((occ_s + new_n_s) <= DEPTH_O)) begin
      accept_s = 1'b1;
    end else if (pix_valid || eol_in) begin
      drop_s = 1'b1;
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  assign in_ready = (occ_s <= RDY_LIM);

  // Stage 1: capture index, raw value and mode; a pending EOL marker takes precedence
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_r <= 1'b0; s1_eol_r <= 1'b0; s1_lut_r <= 1'b0; s1_bgnd_r <= 1'b0;
      s1_idx_r <= 5'd0; s1_raw_r <= 16'h0000; eol_pend_r <= 1'b0;
    end else if (flush) begin
      s1_v_r <= 1'b0; eol_pend_r <= 1'b0;
    end else if (eol_pend_r) begin
      s1_v_r <= 1'b1; s1_eol_r <= 1'b1; s1_lut_r <= 1'b0; s1_raw_r <= 16'h0000;
      eol_pend_r <= 1'b0;
    end else if (accept_s) begin
      s1_v_r    <= 1'b1;
      s1_eol_r  <= !pix_valid;
      s1_lut_r  <= lut_s;
      s1_bgnd_r <= bgnd;
      s1_idx_r  <= idx_s;
      s1_raw_r  <= raw_s;
      eol_pend_r <= pix_valid && eol_in;
    end else begin
      s1_v_r <= 1'b0; eol_pend_r <= 1'b0;
    end
  end

  // Stage 2: registered PLUT read alongside the stage 1 payload
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_v_r <= 1'b0; s2_eol_r <= 1'b0; s2_lut_r <= 1'b0; s2_bgnd_r <= 1'b0;
      s2_raw_r <= 16'h0000; s2_plut_r <= 16'h0000;
    end else if (flush) begin
      s2_v_r <= 1'b0;
    end else begin
      s2_v_r    <= s1_v_r;
      s2_eol_r  <= s1_eol_r;
      s2_lut_r  <= s1_lut_r;
      s2_bgnd_r <= s1_bgnd_r;
      s2_raw_r  <= s1_raw_r;
      s2_plut_r <= plut_r[s1_idx_r];
    end
  end

  // Final pixel value and transparency for the FIFO write
  always_comb begin
    if (s2_eol_r) begin
      res_s = 16'h0000;
    end else if (s2_lut_r) begin
      res_s = s2_plut_r;
    end else begin
      res_s = s2_raw_r;
    end
    transp_s  = s2_eol_r || ((res_s == 16'h0000) && !s2_bgnd_r);
    push_s    = s2_v_r && !flush;
    pop_s     = out_ready && (count_r != {CW{1'b0}}) && !flush;
    push_ok_s = push_s && ((count_r != DEPTH_C) || pop_s);
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= {s2_eol_r, transp_s, res_s};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}}; rd_ptr_r <= {AW{1'b0}}; count_r <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}}; rd_ptr_r <= {AW{1'b0}}; count_r <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      overflow_r <= overflow_r || drop_s;
    end
  end

  // Show-ahead head; outputs held at zero while the FIFO is empty
  always_comb begin
    head_s    = fifo_mem_r[rd_ptr_r];
    out_valid = (count_r != {CW{1'b0}});
    if (out_valid) begin
      out_pix    = head_s[15:0];
      out_transp = head_s[16];
      out_eol    = head_s[17];
    end else begin
      out_pix    = 16'h0000;
      out_transp = 1'b0;
      out_eol    = 1'b0;
    end
  end

  assign plut_done = plut_done_r;
  assign overflow  = overflow_r;

endmodule
